// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_pkg                                                  |
// | Brief    : Shared types and defaults for the data-memory arbiter.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam int c_DEF_AW         = 32;
    localparam int c_DEF_DW         = 32;
    localparam int c_DEF_MEM_LAT    = 2;
    localparam int c_DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        EXT_BUSY = 2'd2
    } state_t;

    // Bits needed to hold 0..max_val inclusive, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_lat_timer                                            |
// | Brief    : Loadable access-latency down-counter with a done flag.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmem_lat_timer
    import dmem_pkg::*;
#(
    parameter int LAT = c_DEF_MEM_LAT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int              c_CW   = cnt_width(LAT);
    localparam logic [c_CW-1:0] c_LOAD = c_CW'(LAT);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    // The last busy cycle is the one where the counter reads one.
    assign o_done = (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_arbiter                                              |
// | Brief    : Shares the data-memory port between the M stage and an    |
// |            external port, with starvation-guaranteed ext service.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = c_DEF_AW,
    parameter int DW         = c_DEF_DW,
    parameter int MEM_LAT    = c_DEF_MEM_LAT,
    parameter int STARVE_MAX = c_DEF_STARVE_MAX
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              c_SW         = cnt_width(STARVE_MAX);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);
    localparam logic [c_SW-1:0] c_SONE       = c_SW'(1);

    state_t          r_state;
    state_t          w_next;
    logic [c_SW-1:0] r_starve;
    logic            w_done;
    logic            w_grant_cpu;
    logic            w_grant_ext;
    logic            w_cpu_done;
    logic            w_ext_done;

    dmem_lat_timer #(
        .LAT (MEM_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (mem_en),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grants only happen out of reset, so every output below is quiet in reset.
    always_comb begin
        w_next      = r_state;
        w_grant_cpu = 1'b0;
        w_grant_ext = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n) begin
                    if (cpu_req && ext_req) begin
                        w_grant_ext = (r_starve == c_STARVE_MAX);
                        w_grant_cpu = (r_starve != c_STARVE_MAX);
                    end else begin
                        w_grant_cpu = cpu_req;
                        w_grant_ext = ext_req;
                    end
                end
                if (w_grant_cpu) begin
                    w_next = CPU_BUSY;
                end else if (w_grant_ext) begin
                    w_next = EXT_BUSY;
                end
            end
            CPU_BUSY, EXT_BUSY: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Waiting ext cycles; held at the cap until ext is granted or withdraws.
    always_ff @(posedge clk) begin
        if (!rst_n || !ext_req || w_grant_ext) begin
            r_starve <= '0;
        end else if (r_starve != c_STARVE_MAX) begin
            r_starve <= r_starve + c_SONE;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_grant_ext) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    assign mem_en     = w_grant_cpu | w_grant_ext;
    assign w_cpu_done = rst_n & (r_state == CPU_BUSY) & w_done;
    assign w_ext_done = rst_n & (r_state == EXT_BUSY) & w_done;

    // Load data flows straight through so MEM/WB captures it at the done edge.
    assign cpu_stall = rst_n & cpu_req & ~w_cpu_done;
    assign cpu_rdata = w_cpu_done ? mem_rdata : '0;
    assign ext_done  = w_ext_done;
    assign ext_rdata = w_ext_done ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port between the pipeline M stage and an external loader/debug port.
- The M stage presents its load/store from the EX/MEM register outputs (ALUOutM address, DMdinM data, DMWEM write enable).
- The block issues fixed-latency memory accesses, stalls the pipeline until the CPU access completes, and uses a starvation counter so the external port is guaranteed service.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, cycles from mem_en issue to mem_rdata valid (≥1); stores use the same completion time
- STARVE_MAX, 4, consecutive cycles ext_req may wait before it wins priority over the CPU (≥1)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  synchronous reset, active low
- cpu_req  in  1  M stage has a load or store this cycle (MtoRFSelM | DMWEM)
- cpu_we  in  1  store (DMWEM)
- cpu_addr  in  AW  ALUOutM
- cpu_wdata  in  DW  DMdinM
- cpu_rdata  out  DW  load data, valid in the CPU done cycle
- cpu_stall  out  1  freeze PC/IF/ID/EX/MEM registers
- ext_req  in  1  external access request; must be held until ext_done
- ext_we  in  1  external store
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_rdata  out  DW  external load data, valid in the ext_done cycle
- ext_done  out  1  one-cycle completion pulse
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write strobe, qualifies mem_en
- mem_addr  out  AW  address, valid with mem_en
- mem_wdata  out  DW  write data, valid with mem_en
- mem_rdata  in  DW  read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset: clk and rst_n only; no asynchronous reset.
  - On rst_n=0 at a clk edge: state=IDLE, lat_cnt=0, starve_cnt=0.
  - All outputs 0 while in reset and after it.
  - Reset mid-transaction abandons the transaction: no done pulse, no stall afterwards.
- FSM has three states: IDLE, CPU_BUSY, EXT_BUSY.
- IDLE grant rules:
  - Both requesting: CPU wins unless starve_cnt==STARVE_MAX, in which case EXT wins.
  - Only one requesting: that requester wins.
  - On grant: mem_en=1 for that cycle with the winner's we/addr/wdata; lat_cnt loads MEM_LAT; state moves to the winner's BUSY state.
- BUSY states:
  - lat_cnt decrements every cycle.
  - The cycle with lat_cnt==1 is the done cycle; it returns to IDLE at the next edge.
  - The next grant happens no earlier than the cycle after done, so back-to-back accesses have a 1-cycle gap.
  - mem_en=0 throughout BUSY.
- CPU done cycle:
  - cpu_stall=0.
  - cpu_rdata=mem_rdata as a combinational pass-through, so the MEM/WB register captures it at that edge.
  - Store completion is signalled identically.
- cpu_stall = cpu_req & ~(state==CPU_BUSY & done).
  - Asserted in the grant cycle.
  - Asserted while EXT is busy.
  - Asserted while the CPU is losing arbitration.
- An unblocked CPU access therefore stalls exactly MEM_LAT cycles.
- EXT done cycle: ext_done=1 and ext_rdata=mem_rdata; both are 0 otherwise.
- ext_req dropped during EXT_BUSY is ignored; the access completes and ext_done still pulses.
- cpu_req dropped while waiting is impossible because the pipeline is stalled; if it happens during CPU_BUSY the access still completes.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on every cycle where ext_req=1 and no EXT grant occurs.
  - Clears on EXT grant and whenever ext_req=0.
- No read-modify-write and no byte enables; accesses are full DW words.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, CPU_BUSY, EXT_BUSY}
  - default AW/DW/MEM_LAT
- Natural sub-module: dmem_lat_timer, a loadable down-counter with a done flag for lat_cnt.
- Arbitration and muxing remain in the top module.

Test Plan:
- CPU load only (MEM_LAT=2): cpu_req=1, addr=0x10 at cycle 0.
  - Expect mem_en at cycle 0 and cpu_stall=1 in cycles 0–1.
  - Cycle 2: stall=0 and cpu_rdata=mem_rdata (model returns 0xDEADBEEF).
- CPU store: we=1, addr=0x20, wdata=0x12345678.
  - Expect one mem_en/mem_we pulse with those values and stall for exactly 2 cycles.
  - A readback load returns 0x12345678.
- Simultaneous requests at idle, starve_cnt=0: CPU granted first.
  - EXT granted after CPU done plus 1 gap cycle.
  - ext_done pulses once with the correct data.
- Starvation: ext_req held while cpu_req is continuously asserted with fresh accesses.
  - After 4 waiting cycles EXT wins the next IDLE tie.
  - cpu_stall stays high during EXT_BUSY.
  - starve_cnt returns to 0.
- rst_n=0 for 1 cycle during CPU_BUSY (lat_cnt=1).
  - Next cycle: state IDLE, cpu_stall=0, no done pulses.
  - A new request is then served normally.
- ext_req dropped in the cycle after EXT grant: ext_done still pulses at grant+2 and no second mem_en occurs.
